// File: rtl/approx_add_pkg.sv
// Shared types and elaboration helpers for the pipelined lower-part-OR approximate adder.
// Holds the per-transaction mode encoding, segment sizing and parameter legality checks.
package approx_add_pkg;

   typedef enum logic {
      MODE_EXACT  = 1'b0,
      MODE_APPROX = 1'b1
   } mode_t;

   localparam int MAX_WIDTH  = 64;
   localparam int MAX_STAGES = 4;

   // Bits per carry-chain segment; the last segment may carry zero padding.
   function automatic int seg_width(input int width, input int stages);
      return (width + stages - 1) / stages;
   endfunction

   // Low k bits of the approximate sum: plain OR of the operands, upper bits cleared.
   function automatic logic [MAX_WIDTH-1:0] loa_low(input logic [MAX_WIDTH-1:0] a,
                                                    input logic [MAX_WIDTH-1:0] b,
                                                    input int k);
      logic [MAX_WIDTH-1:0] mask;
      mask = '0;
      for (int i = 0; i < MAX_WIDTH; i++) begin
         mask[i] = (i < k);
      end
      return (a | b) & mask;
   endfunction

   function automatic bit params_ok(input int width, input int approx_lsb,
                                    input int stages, input int stat_w);
      return (width >= 2) && (width <= MAX_WIDTH) &&
             (approx_lsb >= 0) && (approx_lsb < width) &&
             (stages >= 1) && (stages <= MAX_STAGES) &&
             (stat_w >= 1);
   endfunction

endpackage

// File: rtl/approx_add_seg.sv
// One carry-chain segment of the approximate adder plus its pipeline register.
// With ERR_STATS_EN defined, an exact shadow chain is computed and registered alongside.
module approx_add_seg
   import approx_add_pkg::*;
#(
   parameter int BASE  = 0,
   parameter int SEG_W = 4,
   parameter int PAD_W = 8,
   parameter int K     = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             in_valid,
   input  mode_t            in_mode,
   input  logic [PAD_W-1:0] in_a,
   input  logic [PAD_W-1:0] in_b,
   input  logic [PAD_W-1:0] in_sum,
   input  logic             in_carry,
`ifdef ERR_STATS_EN
   input  logic [PAD_W-1:0] in_xsum,
   input  logic             in_xcarry,
   output logic [PAD_W-1:0] out_xsum,
   output logic             out_xcarry,
`endif
   output logic             out_valid,
   output mode_t            out_mode,
   output logic [PAD_W-1:0] out_a,
   output logic [PAD_W-1:0] out_b,
   output logic [PAD_W-1:0] out_sum,
   output logic             out_carry
);

   logic             approx;
   logic [SEG_W:0]   c;
   logic [SEG_W-1:0] s;
   logic [PAD_W-1:0] sum_next;

   logic             valid_reg;
   mode_t            mode_reg;
   logic [PAD_W-1:0] a_reg;
   logic [PAD_W-1:0] b_reg;
   logic [PAD_W-1:0] sum_reg;
   logic             carry_reg;

   assign approx = (in_mode == MODE_APPROX);
   assign c[0]   = in_carry;

   // Bits below K are OR-ed in approximate mode; only bit K-1 feeds a carry upward.
   for (genvar gi = 0; gi < SEG_W; gi++) begin : g_bit
      localparam int BIT = BASE + gi;
      logic ai;
      logic bi;
      logic maj;
      assign ai  = in_a[BIT];
      assign bi  = in_b[BIT];
      assign maj = (ai & bi) | (c[gi] & (ai ^ bi));
      if (BIT < K) begin : g_loa
         assign s[gi] = approx ? (ai | bi) : (ai ^ bi ^ c[gi]);
         if (BIT == K - 1) begin : g_top
            assign c[gi+1] = approx ? (ai & bi) : maj;
         end else begin : g_mid
            assign c[gi+1] = approx ? 1'b0 : maj;
         end
      end else begin : g_full
         assign s[gi]   = ai ^ bi ^ c[gi];
         assign c[gi+1] = maj;
      end
   end

   always_comb begin
      sum_next = in_sum;
      sum_next[BASE +: SEG_W] = s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= 1'b0;
         mode_reg  <= MODE_EXACT;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
      end else if (en) begin
         valid_reg <= in_valid;
         mode_reg  <= in_mode;
         a_reg     <= in_a;
         b_reg     <= in_b;
         sum_reg   <= sum_next;
         carry_reg <= c[SEG_W];
      end
   end

   assign out_valid = valid_reg;
   assign out_mode  = mode_reg;
   assign out_a     = a_reg;
   assign out_b     = b_reg;
   assign out_sum   = sum_reg;
   assign out_carry = carry_reg;

`ifdef ERR_STATS_EN
   logic [SEG_W:0]   xc;
   logic [SEG_W-1:0] xs;
   logic [PAD_W-1:0] xsum_next;
   logic [PAD_W-1:0] xsum_reg;
   logic             xcarry_reg;

   assign xc[0] = in_xcarry;

   for (genvar gi = 0; gi < SEG_W; gi++) begin : g_xbit
      localparam int BIT = BASE + gi;
      assign xs[gi]   = in_a[BIT] ^ in_b[BIT] ^ xc[gi];
      assign xc[gi+1] = (in_a[BIT] & in_b[BIT]) | (xc[gi] & (in_a[BIT] ^ in_b[BIT]));
   end

   always_comb begin
      xsum_next = in_xsum;
      xsum_next[BASE +: SEG_W] = xs;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xsum_reg   <= '0;
         xcarry_reg <= 1'b0;
      end else if (en) begin
         xsum_reg   <= xsum_next;
         xcarry_reg <= xc[SEG_W];
      end
   end

   assign out_xsum   = xsum_reg;
   assign out_xcarry = xcarry_reg;
`endif

endmodule

// File: rtl/approx_add_pipe.sv
// Pipelined approximate adder (lower-part OR, exact upper carry chain) behind valid/ready.
// Define ERR_STATS_EN to enable the exact shadow adder and the err_cnt/err_max/err_sum counters.
module approx_add_pipe
   import approx_add_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int APPROX_LSB = 2,
   parameter int STAGES     = 2,
   parameter int STAT_W     = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_a,
   input  logic [WIDTH-1:0]  in_b,
   input  logic              in_exact,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH:0]    out_sum,
   input  logic              stats_clr,
   output logic [STAT_W-1:0] err_cnt,
   output logic [WIDTH:0]    err_max,
   output logic [STAT_W-1:0] err_sum
);

   localparam int SEG_W = seg_width(WIDTH, STAGES);
   localparam int PAD_W = SEG_W * STAGES;

   if (!params_ok(WIDTH, APPROX_LSB, STAGES, STAT_W)) begin : g_cfg_check
      $error("approx_add_pipe: illegal parameter combination");
   end

   logic             stall;
   logic             en;
   logic             v_s   [0:STAGES];
   mode_t            m_s   [0:STAGES];
   logic [PAD_W-1:0] a_s   [0:STAGES];
   logic [PAD_W-1:0] b_s   [0:STAGES];
   logic [PAD_W-1:0] sum_s [0:STAGES];
   logic             c_s   [0:STAGES];
   logic [PAD_W:0]   tot;
   logic             unused_bits;

   // A held result freezes every stage; bubbles are not squeezed out.
   assign stall    = v_s[STAGES] & ~out_ready;
   assign en       = ~stall;
   assign in_ready = en;

   assign v_s[0]   = in_valid;
   assign m_s[0]   = in_exact ? MODE_EXACT : MODE_APPROX;
   assign a_s[0]   = PAD_W'(in_a);
   assign b_s[0]   = PAD_W'(in_b);
   assign sum_s[0] = '0;
   assign c_s[0]   = 1'b0;

`ifdef ERR_STATS_EN
   logic [PAD_W-1:0] xsum_s [0:STAGES];
   logic             xc_s   [0:STAGES];
   assign xsum_s[0] = '0;
   assign xc_s[0]   = 1'b0;
`endif

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      approx_add_seg #(
         .BASE  (gi * SEG_W),
         .SEG_W (SEG_W),
         .PAD_W (PAD_W),
         .K     (APPROX_LSB)
      ) u_seg (
         .clk        (clk),
         .rst_n      (rst_n),
         .en         (en),
         .in_valid   (v_s[gi]),
         .in_mode    (m_s[gi]),
         .in_a       (a_s[gi]),
         .in_b       (b_s[gi]),
         .in_sum     (sum_s[gi]),
         .in_carry   (c_s[gi]),
`ifdef ERR_STATS_EN
         .in_xsum    (xsum_s[gi]),
         .in_xcarry  (xc_s[gi]),
         .out_xsum   (xsum_s[gi+1]),
         .out_xcarry (xc_s[gi+1]),
`endif
         .out_valid  (v_s[gi+1]),
         .out_mode   (m_s[gi+1]),
         .out_a      (a_s[gi+1]),
         .out_b      (b_s[gi+1]),
         .out_sum    (sum_s[gi+1]),
         .out_carry  (c_s[gi+1])
      );
   end

   // Zero padding above WIDTH lets the final carry ripple into bit WIDTH.
   assign tot       = {c_s[STAGES], sum_s[STAGES]};
   assign out_sum   = tot[WIDTH:0];
   assign out_valid = v_s[STAGES];

`ifdef ERR_STATS_EN
   localparam int ACC_W = ((STAT_W > WIDTH + 1) ? STAT_W : WIDTH + 1) + 1;

   logic [PAD_W:0]    xtot;
   logic [WIDTH:0]    exact_sum;
   logic              upd;
   logic [WIDTH:0]    abs_err;
   logic [ACC_W-1:0]  sum_wide;
   logic [STAT_W-1:0] err_cnt_reg, err_cnt_next;
   logic [WIDTH:0]    err_max_reg, err_max_next;
   logic [STAT_W-1:0] err_sum_reg, err_sum_next;

   assign xtot      = {xc_s[STAGES], xsum_s[STAGES]};
   assign exact_sum = xtot[WIDTH:0];
   assign upd       = out_valid & out_ready & (m_s[STAGES] == MODE_APPROX);
   assign abs_err   = (out_sum > exact_sum) ? (out_sum - exact_sum) : (exact_sum - out_sum);
   assign sum_wide  = ACC_W'(err_sum_reg) + ACC_W'(abs_err);

   always_comb begin
      err_cnt_next = err_cnt_reg;
      err_max_next = err_max_reg;
      err_sum_next = err_sum_reg;
      if (stats_clr) begin
         err_cnt_next = '0;
         err_max_next = '0;
         err_sum_next = '0;
      end else if (upd) begin
         if ((abs_err != '0) && (err_cnt_reg != {STAT_W{1'b1}})) begin
            err_cnt_next = err_cnt_reg + 1'b1;
         end
         if (abs_err > err_max_reg) begin
            err_max_next = abs_err;
         end
         if (sum_wide > ACC_W'({STAT_W{1'b1}})) begin
            err_sum_next = {STAT_W{1'b1}};
         end else begin
            err_sum_next = sum_wide[STAT_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_reg <= '0;
         err_max_reg <= '0;
         err_sum_reg <= '0;
      end else begin
         err_cnt_reg <= err_cnt_next;
         err_max_reg <= err_max_next;
         err_sum_reg <= err_sum_next;
      end
   end

   assign err_cnt = err_cnt_reg;
   assign err_max = err_max_reg;
   assign err_sum = err_sum_reg;

   assign unused_bits = ^{tot, xtot, a_s[STAGES], b_s[STAGES]};
`else
   assign err_cnt = '0;
   assign err_max = '0;
   assign err_sum = '0;

   assign unused_bits = ^{tot, a_s[STAGES], b_s[STAGES], m_s[STAGES], stats_clr};
`endif

endmodule

// File: tb/tb_approx_add_pipe.sv
// Directed self-checking bench for approx_add_pipe (WIDTH=8, APPROX_LSB=2, STAGES=2).
// Statistics expectations apply when ERR_STATS_EN is defined; otherwise err_* must stay 0.
module tb_approx_add_pipe;

   localparam int WIDTH      = 8;
   localparam int APPROX_LSB = 2;
   localparam int STAGES     = 2;
   localparam int STAT_W     = 32;
`ifdef ERR_STATS_EN
   localparam bit STATS_ON = 1'b1;
`else
   localparam bit STATS_ON = 1'b0;
`endif

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_a;
   logic [WIDTH-1:0]  in_b;
   logic              in_exact;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH:0]    out_sum;
   logic              stats_clr;
   logic [STAT_W-1:0] err_cnt;
   logic [WIDTH:0]    err_max;
   logic [STAT_W-1:0] err_sum;

   int n_tests;
   int n_fail;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       ex;
      logic [8:0] sum;
      int         cnt;
      int         mx;
      int         sm;
   } vec_t;

   vec_t vecs [0:6];

   approx_add_pipe #(
      .WIDTH      (WIDTH),
      .APPROX_LSB (APPROX_LSB),
      .STAGES     (STAGES),
      .STAT_W     (STAT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_exact  (in_exact),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .stats_clr (stats_clr),
      .err_cnt   (err_cnt),
      .err_max   (err_max),
      .err_sum   (err_sum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Send one operand pair with out_ready high; return the result and its latency in cycles.
   task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic ex,
                          input logic clr_on_out, output logic [8:0] sum, output int lat);
      in_a     = a;
      in_b     = b;
      in_exact = ex;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         tick();
         lat++;
      end
      sum       = out_sum;
      stats_clr = clr_on_out;
      tick();
      stats_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_exact  = 1'b0;
      out_ready = 1'b1;
      stats_clr = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0d expected 0", out_valid); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0d expected 1", in_ready); end
      n_tests++; if (out_sum !== 9'd0) begin n_fail++; $display("FAIL reset_out_sum: got %0d expected 0", out_sum); end
      n_tests++; if (err_cnt !== '0 || err_max !== '0 || err_sum !== '0) begin
         n_fail++; $display("FAIL reset_stats: got cnt=%0d max=%0d sum=%0d expected 0/0/0", err_cnt, err_max, err_sum);
      end
      $display("[TB] reset done: out_valid=%0d in_ready=%0d", out_valid, in_ready);
   endtask

   task automatic test_modes();
      logic [8:0] sum;
      int lat;
      vecs[0] = '{8'd3,   8'd1,   1'b0, 9'd3,   1, 1, 1};
      vecs[1] = '{8'd2,   8'd2,   1'b0, 9'd6,   2, 2, 3};
      vecs[2] = '{8'd2,   8'd2,   1'b1, 9'd4,   2, 2, 3};
      vecs[3] = '{8'd255, 8'd255, 1'b0, 9'd511, 3, 2, 4};
      vecs[4] = '{8'd255, 8'd255, 1'b1, 9'd510, 3, 2, 4};
      vecs[5] = '{8'd4,   8'd8,   1'b0, 9'd12,  3, 2, 4};
      vecs[6] = '{8'd1,   8'd1,   1'b0, 9'd1,   4, 2, 5};
      for (int i = 0; i < 7; i++) begin
         run_one(vecs[i].a, vecs[i].b, vecs[i].ex, 1'b0, sum, lat);
         $display("[TB] mode a=%0d b=%0d exact=%0d sum=%0d lat=%0d cnt=%0d max=%0d esum=%0d",
                  vecs[i].a, vecs[i].b, vecs[i].ex, sum, lat, err_cnt, err_max, err_sum);
         n_tests++; if (sum !== vecs[i].sum) begin n_fail++; $display("FAIL mode_sum[%0d]: got %0d expected %0d", i, sum, vecs[i].sum); end
         n_tests++; if (lat !== STAGES) begin n_fail++; $display("FAIL mode_latency[%0d]: got %0d expected %0d", i, lat, STAGES); end
         n_tests++; if (err_cnt !== STAT_W'(STATS_ON ? vecs[i].cnt : 0)) begin
            n_fail++; $display("FAIL mode_err_cnt[%0d]: got %0d expected %0d", i, err_cnt, STATS_ON ? vecs[i].cnt : 0);
         end
         n_tests++; if (err_max !== 9'(STATS_ON ? vecs[i].mx : 0)) begin
            n_fail++; $display("FAIL mode_err_max[%0d]: got %0d expected %0d", i, err_max, STATS_ON ? vecs[i].mx : 0);
         end
         n_tests++; if (err_sum !== STAT_W'(STATS_ON ? vecs[i].sm : 0)) begin
            n_fail++; $display("FAIL mode_err_sum[%0d]: got %0d expected %0d", i, err_sum, STATS_ON ? vecs[i].sm : 0);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] op_a [0:3];
      logic [7:0] op_b [0:3];
      logic [8:0] exp_s [0:3];
      logic [8:0] held;
      bit held_v;
      bit saw_full;
      bit in_fire;
      int tx;
      int rx;
      op_a[0] = 8'd10;  op_b[0] = 8'd20;  exp_s[0] = 9'd30;
      op_a[1] = 8'd1;   op_b[1] = 8'd2;   exp_s[1] = 9'd3;
      op_a[2] = 8'd100; op_b[2] = 8'd27;  exp_s[2] = 9'd127;
      op_a[3] = 8'd200; op_b[3] = 8'd100; exp_s[3] = 9'd300;
      tx = 0; rx = 0; held_v = 1'b0; saw_full = 1'b0; held = '0;
      in_exact = 1'b1;
      for (int cyc = 0; cyc < 40 && rx < 4; cyc++) begin
         out_ready = (cyc >= 5);
         in_valid  = (tx < 4);
         if (tx < 4) begin
            in_a = op_a[tx];
            in_b = op_b[tx];
         end
         #1;
         if (!in_ready) saw_full = 1'b1;
         if (held_v && out_valid) begin
            n_tests++; if (out_sum !== held) begin n_fail++; $display("FAIL bp_hold: got %0d expected %0d", out_sum, held); end
         end
         held_v = out_valid && !out_ready;
         held   = out_sum;
         if (out_valid && out_ready) begin
            $display("[TB] bp rx=%0d sum=%0d cyc=%0d", rx, out_sum, cyc);
            n_tests++; if (out_sum !== exp_s[rx]) begin n_fail++; $display("FAIL bp_order[%0d]: got %0d expected %0d", rx, out_sum, exp_s[rx]); end
            rx++;
         end
         in_fire = in_valid && in_ready;
         tick();
         if (in_fire) tx++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n_tests++; if (saw_full !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_low: got %0d expected 1", saw_full); end
      n_tests++; if (rx !== 4) begin n_fail++; $display("FAIL bp_delivered: got %0d expected 4", rx); end
      n_tests++; if (tx !== 4) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 4", tx); end
      for (int i = 0; i < 4; i++) begin
         n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup[%0d]: got %0d expected 0", i, out_valid); end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      bit stale;
      out_ready = 1'b0;
      in_exact  = 1'b0;
      in_a = 8'd3; in_b = 8'd1; in_valid = 1'b1;
      tick();
      in_a = 8'd1; in_b = 8'd1;
      tick();
      in_valid = 1'b0;
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rm_inflight: got %0d expected 1", out_valid); end
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_out_valid: got %0d expected 0", out_valid); end
      n_tests++; if (err_cnt !== '0 || err_max !== '0 || err_sum !== '0) begin
         n_fail++; $display("FAIL rm_stats: got cnt=%0d max=%0d sum=%0d expected 0/0/0", err_cnt, err_max, err_sum);
      end
      #3 rst_n = 1'b1;
      out_ready = 1'b1;
      stale = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (out_valid) stale = 1'b1;
      end
      $display("[TB] reset mid-flight: stale=%0d in_ready=%0d", stale, in_ready);
      n_tests++; if (stale !== 1'b0) begin n_fail++; $display("FAIL rm_no_stale: got %0d expected 0", stale); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_in_ready: got %0d expected 1", in_ready); end
   endtask

   task automatic test_stats_clr();
      logic [8:0] sum;
      int lat;
      run_one(8'd3, 8'd1, 1'b0, 1'b0, sum, lat);
      $display("[TB] clr pre a=3 b=1 sum=%0d cnt=%0d", sum, err_cnt);
      n_tests++; if (err_cnt !== STAT_W'(STATS_ON ? 1 : 0)) begin
         n_fail++; $display("FAIL clr_pre_cnt: got %0d expected %0d", err_cnt, STATS_ON ? 1 : 0);
      end
      run_one(8'd2, 8'd2, 1'b0, 1'b1, sum, lat);
      $display("[TB] clr a=2 b=2 sum=%0d cnt=%0d max=%0d esum=%0d", sum, err_cnt, err_max, err_sum);
      n_tests++; if (sum !== 9'd6) begin n_fail++; $display("FAIL clr_sum: got %0d expected 6", sum); end
      n_tests++; if (err_cnt !== '0) begin n_fail++; $display("FAIL clr_cnt: got %0d expected 0", err_cnt); end
      n_tests++; if (err_max !== '0 || err_sum !== '0) begin
         n_fail++; $display("FAIL clr_max_sum: got max=%0d sum=%0d expected 0/0", err_max, err_sum);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_modes();
      test_backpressure();
      test_reset_mid();
      test_stats_clr();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
